// File: rtl/vga_frame_buffer.sv
// Purpose : double-buffered VGA pixel store; the GPU draws into the back bank, the display reads the front bank.
// Latency : vga_data follows vga_addr by 1 cycle; swaps complete on the first v_sync falling edge after the request.
// Backpres: wr_ready is high only when idle; a clear holds it low for 2^ADDR_W cycles, a pending swap until the edge.
//
// Ports:
//   clk, rst             - clock; asynchronous active-low reset
//   vga_addr / vga_data  - display read port on the front bank (registered)
//   v_sync               - vertical sync, active low; its falling edge commits a pending swap
//   wr_valid / wr_ready  - GPU write handshake into the back bank (wr_addr, wr_data)
//   swap_req, clear_req  - one-cycle requests, honoured only while idle (clear wins if both are high)
//   clear_value          - fill value captured when a clear is accepted
//   busy, done           - not idle / one-cycle completion pulse for a swap or a clear
//   front_sel            - index of the bank currently being displayed
module vga_frame_buffer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              v_sync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_value,
    output logic              busy,
    output logic              done,
    output logic              front_sel
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_CELL = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_val;
    logic              vs_q;
    logic              vs_fall;

    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic              clr_start;
    logic              swap_commit;

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    // Previous cycle high, this cycle low.
    assign vs_fall = vs_q & ~v_sync;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        wr_ready    = 1'b0;
        done        = 1'b0;
        bank_we     = 1'b0;
        bank_waddr  = wr_addr;
        bank_wdata  = wr_data;
        clr_start   = 1'b0;
        swap_commit = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                // A write accepted alongside clear_req still lands; the clear
                // later overwrites it like any other cell.
                bank_we  = wr_valid;
                if (clear_req) begin
                    clr_start = 1'b1;
                    state_nxt = CLEAR;
                end else if (swap_req) begin
                    // An edge in this same cycle is deliberately not acted on.
                    state_nxt = SWAP_WAIT;
                end
            end
            CLEAR: begin
                bank_we    = 1'b1;
                bank_waddr = clr_cnt;
                bank_wdata = clr_val;
                if (clr_cnt == LAST_CELL) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (vs_fall) begin
                    swap_commit = 1'b1;
                    done        = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            clr_cnt   <= '0;
            clr_val   <= '0;
            vs_q      <= 1'b1;
            vga_data  <= '0;
        end else begin
            state <= state_nxt;
            vs_q  <= v_sync;
            if (swap_commit) begin
                front_sel <= ~front_sel;
            end
            if (clr_start) begin
                clr_cnt <= '0;
                clr_val <= clear_value;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            // Uses the front_sel of this cycle, before any toggle lands.
            vga_data <= front_sel ? bank1[vga_addr] : bank0[vga_addr];
        end
    end

    // Storage is never reset. Writes always target the bank not on display,
    // so the read port above never sees GPU or clear traffic.
    always_ff @(posedge clk) begin
        if (rst && bank_we && front_sel) begin
            bank0[bank_waddr] <= bank_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && bank_we && !front_sel) begin
            bank1[bank_waddr] <= bank_wdata;
        end
    end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Purpose : directed bench for vga_frame_buffer with a per-cycle reference model and literal spot checks.
// Latency : model predicts vga_data one cycle after vga_addr, done in the completing cycle.
// Backpres: model tracks idle/clearing/waiting to predict wr_ready and busy.
module tb_vga_frame_buffer;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_data;
    logic          v_sync = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          swap_req = 1'b0;
    logic          clear_req = 1'b0;
    logic [DW-1:0] clear_value = '0;
    logic          busy;
    logic          done;
    logic          front_sel;

    vga_frame_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .vga_addr(vga_addr), .vga_data(vga_data),
        .v_sync(v_sync), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
        .clear_req(clear_req), .clear_value(clear_value), .busy(busy),
        .done(done), .front_sel(front_sel)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    bit chk_en = 1'b0;
    bit sweep  = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Activity: 0 = idle, 1 = filling the back bank, 2 = waiting for the sync edge.
    logic [DW-1:0] mb [2][DEPTH];
    bit            mk [2][DEPTH];   // cell has been written since time zero
    int            m_front = 0;
    int            m_act   = 0;
    int            m_left  = 0;     // clear cells still to be written
    logic [DW-1:0] m_cv    = '0;
    bit            m_vs    = 1'b1;
    logic [DW-1:0] m_vga   = '0;
    bit            m_vga_k = 1'b1;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_front = 0; m_act = 0; m_left = 0; m_vs = 1'b1;
                m_vga = '0; m_vga_k = 1'b1;
            end else begin
                bit fell;
                int back;
                fell    = m_vs && !v_sync;
                back    = 1 - m_front;
                m_vga   = mb[m_front][vga_addr];
                m_vga_k = mk[m_front][vga_addr];
                if (m_act == 0) begin
                    if (wr_valid) begin
                        mb[back][wr_addr] = wr_data;
                        mk[back][wr_addr] = 1'b1;
                    end
                    if (clear_req) begin
                        m_act = 1; m_left = DEPTH; m_cv = clear_value;
                    end else if (swap_req) begin
                        m_act = 2;
                    end
                end else if (m_act == 1) begin
                    mb[back][DEPTH - m_left] = m_cv;
                    mk[back][DEPTH - m_left] = 1'b1;
                    m_left--;
                    if (m_left == 0) m_act = 0;
                end else begin
                    if (fell) begin
                        m_front = back;
                        m_act   = 0;
                    end
                end
                m_vs = v_sync;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int exp_done;
                exp_done = ((m_act == 1 && m_left == 1) ||
                            (m_act == 2 && m_vs && !v_sync)) ? 1 : 0;
                check("done", int'(done), exp_done);
                check("busy", int'(busy), (m_act != 0) ? 1 : 0);
                check("wr_ready", int'(wr_ready), (m_act == 0) ? 1 : 0);
                check("front_sel", int'(front_sel), m_front);
                if (m_vga_k) check("vga_data", int'(vga_data), int'(m_vga));
                if (done) done_seen++;
            end
        end
    end

    // Advance one cycle; one-cycle pulses drop automatically afterwards.
    task automatic cyc();
        @(posedge clk);
        #1;
        swap_req  = 1'b0;
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        if (sweep) vga_addr = vga_addr + 12'd37;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #3 rst = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_vga_data", int'(vga_data), 0);
        check("rst_front_sel", int'(front_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        // Write then swap; the edge coinciding with swap_req is ignored.
        check("idle_wr_ready", int'(wr_ready), 1);
        wr_valid = 1'b1; wr_addr = 12'h123; wr_data = 8'h5A; cyc();
        wr_valid = 1'b1; wr_addr = 12'hFFF; wr_data = 8'hEE; cyc();
        swap_req = 1'b1; v_sync = 1'b0; cyc();
        repeat (3) cyc();
        check("same_cycle_edge_front", int'(front_sel), 0);
        check("same_cycle_edge_busy", int'(busy), 1);
        v_sync = 1'b1; cyc();
        v_sync = 1'b0; cyc();
        check("swap_front_sel", int'(front_sel), 1);
        check("swap_busy", int'(busy), 0);
        check("swap_done_count", done_seen, 1);
        sweep = 1'b0;
        vga_addr = 12'h123; cyc();
        check("read_0x123", int'(vga_data), 8'h5A);
        vga_addr = 12'hFFF; cyc();
        check("read_0xFFF", int'(vga_data), 8'hEE);
        sweep = 1'b1;

        // Swap waits as long as v_sync stays high.
        v_sync = 1'b1;
        swap_req = 1'b1; cyc();
        repeat (1000) cyc();
        check("wait_front_sel", int'(front_sel), 1);
        check("wait_busy", int'(busy), 1);
        v_sync = 1'b0; cyc();
        check("wait_edge_front_sel", int'(front_sel), 0);
        v_sync = 1'b1; cyc();
        check("wait_done_count", done_seen, 2);

        // Clear to 0xFF with a same-cycle write; requests during the clear are ignored.
        clear_req = 1'b1; clear_value = 8'hFF;
        wr_valid = 1'b1; wr_addr = 12'h050; wr_data = 8'h33;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            check("clear_busy", int'(busy), 1);
            check("clear_wr_ready", int'(wr_ready), 0);
            if (i == 2000) begin
                clear_req = 1'b1; clear_value = 8'h12; swap_req = 1'b1;
            end
            cyc();
        end
        check("clear_end_busy", int'(busy), 0);
        check("clear_done_count", done_seen, 3);
        swap_req = 1'b1; cyc();
        v_sync = 1'b0; cyc();
        v_sync = 1'b1;
        check("clear_swap_front", int'(front_sel), 1);
        sweep = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vga_addr = AW'(i); cyc();
        end
        vga_addr = 12'h050; cyc();
        check("cleared_0x050", int'(vga_data), 8'hFF);
        vga_addr = 12'h123; cyc();
        check("cleared_0x123", int'(vga_data), 8'hFF);
        check("clear_swap_done_count", done_seen, 4);
        sweep = 1'b1;

        // Simultaneous clear and swap: clear wins, swap is dropped.
        clear_req = 1'b1; swap_req = 1'b1; clear_value = 8'h00; cyc();
        check("simul_busy", int'(busy), 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 1000) check("isolation_mid_clear", int'(vga_data), 8'hFF);
            cyc();
        end
        check("simul_end_busy", int'(busy), 0);
        check("simul_front_after_clear", int'(front_sel), 1);
        v_sync = 1'b0; cyc();
        v_sync = 1'b1; cyc();
        check("simul_front_after_edge", int'(front_sel), 1);
        check("simul_done_count", done_seen, 5);

        // Reset in the middle of a clear, after cells 0..99 were filled.
        clear_req = 1'b1; clear_value = 8'h77; cyc();
        repeat (100) cyc();
        rst = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_vga_data", int'(vga_data), 0);
        check("midrst_wr_ready", int'(wr_ready), 1);
        check("midrst_front_sel", int'(front_sel), 0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        check("postrst_wr_ready", int'(wr_ready), 1);
        check("postrst_busy", int'(busy), 0);
        check("postrst_done_count", done_seen, 5);
        sweep = 1'b0;
        vga_addr = 12'd99; cyc();
        check("partial_clear_99", int'(vga_data), 8'h77);
        vga_addr = 12'd100; cyc();
        check("partial_clear_100", int'(vga_data), 8'h00);
        sweep = 1'b1;
        repeat (300) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_buffer.md
VGA_FRAME_BUFFER -- requirements
Module: vga_frame_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning pixel-cell address width (4096 cells per bank).
REQ-002 SHALL have parameter DATA_W, default 8, meaning cell/colour width, equal to `REG_RANGE width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port vga_addr, input, ADDR_W, meaning display read address from vga_machine.
REQ-006 SHALL have port vga_data, output, DATA_W, meaning registered front-bank read data to vga_machine.
REQ-007 SHALL have port v_sync, input, 1, meaning vertical sync from the timing generator, active low.
REQ-008 SHALL have port wr_valid, input, 1, meaning the GPU presents a write.
REQ-009 SHALL have port wr_ready, output, 1, meaning the block accepts a write this cycle.
REQ-010 SHALL have port wr_addr, input, ADDR_W, meaning back-bank write address.
REQ-011 SHALL have port wr_data, input, DATA_W, meaning back-bank write data.
REQ-012 SHALL have port swap_req, input, 1, meaning a one-cycle request to exchange the front and back banks.
REQ-013 SHALL have port clear_req, input, 1, meaning a one-cycle request to fill the back bank.
REQ-014 SHALL have port clear_value, input, DATA_W, meaning fill value, sampled in the cycle clear_req is accepted.
REQ-015 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-016 SHALL have port done, output, 1, meaning a one-cycle pulse when a swap or clear completes.
REQ-017 SHALL have port front_sel, output, 1, meaning the index of the bank currently displayed.

Function
REQ-018 SHALL hold two banks of 2^ADDR_W x DATA_W storage; the displayed (front) bank is front_sel and the other bank is the back bank.
REQ-019 SHALL register vga_data <= front_bank[vga_addr], giving exactly 1 cycle latency and using the front_sel value of the sampling cycle.
REQ-020 SHALL implement FSM states IDLE, CLEAR and SWAP_WAIT.
REQ-021 SHALL drive wr_ready = 1 only in IDLE; a write occurs to the back bank when wr_valid && wr_ready.
REQ-022 SHALL, in IDLE on clear_req, latch clear_value, reset clr_cnt to 0 and go to CLEAR.
REQ-023 SHALL, in CLEAR, write the latched value to back[clr_cnt] each cycle and increment clr_cnt; at clr_cnt = 2^ADDR_W-1 the final write occurs and the FSM returns to IDLE with done = 1 that cycle. A clear therefore takes 2^ADDR_W cycles.
REQ-024 SHALL, in IDLE on swap_req (with clear_req low), go to SWAP_WAIT.
REQ-025 SHALL detect a v_sync falling edge from a registered copy of v_sync (previous = 1, current = 0).
REQ-026 SHALL, when the edge is detected in SWAP_WAIT, toggle front_sel, pulse done and return to IDLE.
REQ-027 SHALL ignore an edge detected in the same cycle that swap_req is accepted; the swap waits for the next edge.
REQ-028 SHALL give clear_req priority when clear_req and swap_req are high together in IDLE; the swap_req is dropped.
REQ-029 SHALL ignore swap_req and clear_req while busy; they are not queued.
REQ-030 SHALL complete a write accepted in the same IDLE cycle as clear_req; the clear then overwrites that address.
REQ-031 SHALL keep vga_addr reads unaffected by writes and clears, since those touch only the back bank.

Reset
REQ-032 SHALL, on rst low, asynchronously set: state = IDLE, front_sel = 0, vga_data = 0, done = 0, clr_cnt = 0, v_sync history = 1.
REQ-033 SHALL abort any CLEAR or SWAP_WAIT in progress when reset is asserted, with no done pulse; bank contents are not reset.

Verification
REQ-034 SHALL verify write then swap: write 0x5A to back addr 0x123, pulse swap_req, drop v_sync 1->0, then read vga_addr 0x123 -> vga_data = 0x5A one cycle later, front_sel = 1, done pulsed once.
REQ-035 SHALL verify clear: pulse clear_req with clear_value = 0xFF -> busy for 4096 cycles, wr_ready = 0 throughout, done on the last cycle; after a swap every address reads 0xFF.
REQ-036 SHALL verify simultaneous requests: clear_req and swap_req in the same cycle -> CLEAR entered, front_sel unchanged after clear completes and after a subsequent v_sync edge.
REQ-037 SHALL verify swap waiting: hold v_sync = 1 for 1000 cycles after swap_req -> front_sel unchanged, busy = 1; the first falling edge toggles it.
REQ-038 SHALL verify reset mid-clear: assert rst at clr_cnt = 100 -> state IDLE, busy = 0, vga_data = 0, no done pulse, wr_ready = 1 after release.
REQ-039 SHALL verify read isolation: during a CLEAR, vga_data continuously equals the previously written front-bank contents.
